// File: rtl/foo_pipe_pkg.sv
// Shared types and constants for the foo pipeline arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package foo_pipe_pkg;

    localparam int FOO_DATA_W       = 32;
    localparam int FOO_PIPE_LATENCY = 3;

    // Tag ID field is sized for the largest supported requester count (8),
    // so one tag type serves every legal NUM_REQ; unused upper bits stay 0.
    localparam int FOO_TAG_ID_W     = 3;

    // One in-flight slot: valid bit plus originating requester index.
    typedef struct packed {
        logic                    v;
        logic [FOO_TAG_ID_W-1:0] id;
    } foo_tag_t;

endpackage

// File: rtl/foo_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after rr_ptr, wrapping.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; an ineligible requester simply receives no grant.
//
// Ports:
//   eligible  [NUM_REQ]  requesters allowed to issue this cycle
//   rr_ptr    [ID_W]     highest-priority index for this cycle
//   grant     [NUM_REQ]  one-hot grant, all zero when nothing is eligible
//   grant_idx [ID_W]     binary index of the granted requester
//   any_grant            a grant was made
module foo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    always_comb begin : search
        logic [ID_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        // Walk NUM_REQ positions starting at the pointer; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_grant && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/foo_pipe_arbiter.sv
// Shares one fixed-latency foo pipeline among NUM_REQ requesters, routing results back.
// Latency: accept in cycle N -> registered rsp_valid in cycle N+PIPE_LATENCY+1.
// Backpressure: credit-limited req_ready per requester; responses cannot be stalled.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_data/req_ready  per-requester request handshake (ready is one-hot)
//   pipe_input_valid/pipe_x       issue side of the foo pipeline
//   pipe_out/pipe_output_valid    result side of the foo pipeline
//   rsp_valid/rsp_id/rsp_data     one-hot response strobe, index and shared result bus
//   busy                          work in flight or a response being presented
//   tag_error                     sticky: pipeline valid disagreed with the tag pipe
module foo_pipe_arbiter
    import foo_pipe_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ID_W            = 2,
    parameter int DATA_W          = FOO_DATA_W,
    parameter int PIPE_LATENCY    = FOO_PIPE_LATENCY,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pipe_input_valid,
    output logic [DATA_W-1:0]         pipe_x,
    input  logic [DATA_W-1:0]         pipe_out,
    input  logic                      pipe_output_valid,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      tag_error
);

    localparam int CNT_W   = 3;  // holds up to 7 outstanding ops
    localparam int DRAIN_W = $clog2(PIPE_LATENCY + 1);

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic [NUM_REQ-1:0] accept;
    logic [ID_W-1:0]    rr_ptr;
    foo_tag_t           tag_q [PIPE_LATENCY];
    foo_tag_t           tag_last;
    logic [NUM_REQ-1:0] last_onehot;
    logic [DRAIN_W-1:0] drain_cnt;

    // A credit being returned this cycle (rsp_valid set) may be reused in the
    // same cycle, so a single requester with PIPE_LATENCY+1 credits never stalls.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &
                          ((cnt[i] < CNT_W'(MAX_OUTSTANDING)) | rsp_valid[i]);
        end
    end

    foo_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready        = rst ? '0 : grant;
    assign accept           = req_valid & req_ready;
    assign pipe_input_valid = |req_ready;
    assign pipe_x           = pipe_input_valid
                            ? req_data[int'(grant_idx)*DATA_W +: DATA_W]
                            : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Tag pipe mirrors the foo pipeline: the last entry lines up with pipe_output_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].v  <= any_grant;
            tag_q[0].id <= FOO_TAG_ID_W'(grant_idx);
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_last = tag_q[PIPE_LATENCY-1];

    always_comb begin
        last_onehot = '0;
        last_onehot[tag_last.id[ID_W-1:0]] = tag_last.v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= last_onehot;
            rsp_id    <= tag_last.id[ID_W-1:0];
            if (tag_last.v) begin
                rsp_data <= pipe_out;
            end
        end
    end

    // Credit counters: +1 on accept, -1 when the response strobe is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({accept[i], rsp_valid[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // The pipeline's valids settle over PIPE_LATENCY cycles after reset; don't
    // compare against the tag pipe until that window has passed.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= DRAIN_W'(PIPE_LATENCY);
            tag_error <= 1'b0;
        end else begin
            if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
            if ((drain_cnt == '0) && (pipe_output_valid != tag_last.v)) begin
                tag_error <= 1'b1;
            end
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int k = 0; k < PIPE_LATENCY; k++) begin
            busy = busy | tag_q[k].v;
        end
    end

endmodule

// File: tb/tb_foo_pipe_arbiter.sv
// Bench for foo_pipe_arbiter with a behavioural foo pipeline (x+2, 3 cycles).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Expected responses go into a scoreboard queue; a monitor pops on rsp_valid.
module tb_foo_pipe_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            pipe_input_valid;
    logic [DW-1:0]   pipe_x;
    logic [DW-1:0]   pipe_out;
    logic            pipe_output_valid;
    logic [NR-1:0]   rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic            tag_error;

    always #5 clk = ~clk;

    foo_pipe_arbiter #(
        .NUM_REQ         (NR),
        .ID_W            (2),
        .DATA_W          (DW),
        .PIPE_LATENCY    (3),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .pipe_input_valid  (pipe_input_valid),
        .pipe_x            (pipe_x),
        .pipe_out          (pipe_out),
        .pipe_output_valid (pipe_output_valid),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .rsp_data          (rsp_data),
        .busy              (busy),
        .tag_error         (tag_error)
    );

    // Behavioural foo pipeline, reset together with the arbiter.
    logic [2:0]    pv;
    logic [DW-1:0] pd0, pd1, pd2;
    logic          force_ov = 1'b0;

    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[1:0], pipe_input_valid};
        pd0 <= pipe_x + 32'd2;
        pd1 <= pd0;
        pd2 <= pd1;
    end
    assign pipe_output_valid = pv[2] | force_ov;
    assign pipe_out          = pd2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [NR-1:0] oh;
        logic [1:0]    id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    // Monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
                check("rsp_id",    64'(rsp_id),    64'(e.id));
                check("rsp_data",  64'(rsp_data),  64'(e.data));
                check("rsp_cycle", 64'(cyc),       64'(e.due));
            end
        end
    end

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    // One cycle of stimulus: present req_valid, check the grant and issue,
    // and queue the expected response (operand + 2, four cycles later).
    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy);
        exp_t e;
        int   id;
        req_valid = v;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("pipe_input_valid", 64'(pipe_input_valid), 64'(exp_rdy != '0));
        id = 0;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) id = i;
        if (exp_rdy != '0) begin
            check("pipe_x", 64'(pipe_x), 64'(req_data[id*DW +: DW]));
            e.oh   = exp_rdy;
            e.id   = 2'(id);
            e.data = req_data[id*DW +: DW] + 32'd2;
            e.due  = cyc + 4;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state; requests held high must not be granted during reset.
        rst       = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_pipe_iv",   64'(pipe_input_valid), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id",    64'(rsp_id), 64'(0));
        check("rst_rsp_data",  64'(rsp_data), 64'(0));
        check("rst_tag_error", 64'(tag_error), 64'(0));
        check("rst_busy",      64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        idle(2);

        // Single request: 5 -> 7 four cycles later, busy falls one cycle after.
        set_data(0, 32'h0000_0005);
        drive(4'b0001, 4'b0001);
        for (int k = 1; k <= 5; k++) begin
            req_valid = '0;
            @(negedge clk);
            check("single_busy", 64'(busy), 64'(k <= 4));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rsp_data_hold", 64'(rsp_data), 64'(32'h7));
        @(posedge clk);
        #1;

        // Fairness: pointer back to 0, all four requesting continuously.
        do_reset();
        for (int i = 0; i < NR; i++) set_data(i, 32'h100 + 32'(i));
        for (int r = 0; r < 8; r++) begin
            logic [NR-1:0] g;
            g = '0;
            g[r % NR] = 1'b1;
            drive(4'b1111, g);
        end
        idle(6);

        // Credit stall on requester 2 (pointer is 0 here).
        set_data(2, 32'hFFFF_FFFF); drive(4'b0100, 4'b0100);
        set_data(2, 32'h0000_0010); drive(4'b0100, 4'b0100);
        set_data(2, 32'h0000_0020); drive(4'b0100, 4'b0000);
        drive(4'b0100, 4'b0000);
        drive(4'b0100, 4'b0100);   // same cycle as first response
        set_data(2, 32'h0000_0030); drive(4'b0100, 4'b0100);   // second credit returning
        drive(4'b0100, 4'b0000);   // count held at 2, nothing returning
        idle(6);

        // Wrap/skip: pointer now 3, only requesters 1 and 3 requesting.
        set_data(1, 32'h0000_1111);
        set_data(3, 32'h0000_3333);
        drive(4'b1010, 4'b1000);
        drive(4'b1010, 4'b0010);
        drive(4'b1010, 4'b1000);
        idle(6);

        // Reset with three ops in flight.
        set_data(0, 32'h0000_0A00);
        set_data(1, 32'h0000_0B00);
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0001);
        drive(4'b0010, 4'b0010);
        rst       = 1'b1;
        req_valid = 4'b0001;
        sb.delete();
        @(negedge clk);
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_rsp",  64'(rsp_valid), 64'(0));
            check("midrst_tag_err", 64'(tag_error), 64'(0));
            @(posedge clk);
            #1;
        end
        // Counters cleared: requester 0 again gets two credits.
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0000);
        idle(6);

        // Tag mismatch: pipeline claims a result nobody issued.
        force_ov = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("tagerr_before", 64'(tag_error), 64'(0));
        @(posedge clk);
        #1;
        force_ov = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tagerr_sticky", 64'(tag_error), 64'(1));
            @(posedge clk);
            #1;
        end
        do_reset();
        @(negedge clk);
        check("tagerr_cleared", 64'(tag_error), 64'(0));
        @(posedge clk);
        #1;

        idle(2);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
